mem_port_arbiter: RTL and testbench

- Shares one single-port data memory between two requesters: the instruction-fetch port (I, read-only) and the load/store port (D, read/write).
- Inserts a programmable number of wait states to model slow memory.
- Returns read data or a write acknowledge through a registered one-cycle valid pulse.
- Sits between the core datapath and the data memory; the memory itself is unchanged (combinational read gated by mem_read, write on posedge clk).

---
 rtl/mem_port_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch / load-store) arbiter onto a single-port data memory with programmable wait states.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate grants on ties; otherwise the load/store port always wins.
module mem_port_arbiter #(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH_WORDS = 8000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_valid,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic {S_IDLE = 1'b0, S_ACCESS = 1'b1} state_t;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif

  // owner encoding: 0 = fetch port, 1 = load/store port
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        owner_q, owner_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic        last_owner_q, last_owner_d;
  logic        i_valid_q, i_valid_d;
  logic        i_err_q, i_err_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic        d_valid_q, d_valid_d;
  logic        d_err_q, d_err_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  logic        pick_d;
  logic [31:0] sel_addr;
  logic [31:0] resp_data;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    err_d        = err_q;
    last_owner_d = last_owner_q;
    i_valid_d    = 1'b0;
    i_err_d      = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_valid_d    = 1'b0;
    d_err_d      = 1'b0;
    d_rdata_d    = d_rdata_q;
    i_gnt        = 1'b0;
    d_gnt        = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr     = 32'h0;
    mem_wdata    = 32'h0;
    resp_data    = 32'h0;

    // Tie goes to D unless alternating is enabled and D was the last owner.
    pick_d   = d_req & (~i_req | ~RR_EN | ~last_owner_q);
    sel_addr = pick_d ? d_addr : i_addr;

    case (state_q)
      S_IDLE: begin
        if (i_req || d_req) begin
          d_gnt        = pick_d;
          i_gnt        = ~pick_d;
          owner_d      = pick_d;
          last_owner_d = pick_d;
          addr_d       = sel_addr;
          wdata_d      = pick_d ? d_wdata : 32'h0;
          we_d         = pick_d & d_we;
          err_d        = (sel_addr[31:2] >= 30'(DEPTH_WORDS));
          cnt_d        = 4'(WAIT_CYCLES);
          state_d      = S_ACCESS;
        end
      end
      S_ACCESS: begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_read  = ~we_q & ~err_q;
        mem_write = we_q & ~err_q & (cnt_q == 4'd0);
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          resp_data = (we_q || err_q) ? 32'h0 : mem_rdata;
          if (owner_q) begin
            d_rdata_d = resp_data;
            d_valid_d = 1'b1;
            d_err_d   = err_q;
          end else begin
            i_rdata_d = resp_data;
            i_valid_d = 1'b1;
            i_err_d   = err_q;
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      owner_q      <= 1'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      last_owner_q <= 1'b0;
      i_valid_q    <= 1'b0;
      i_err_q      <= 1'b0;
      i_rdata_q    <= 32'h0;
      d_valid_q    <= 1'b0;
      d_err_q      <= 1'b0;
      d_rdata_q    <= 32'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      err_q        <= err_d;
      last_owner_q <= last_owner_d;
      i_valid_q    <= i_valid_d;
      i_err_q      <= i_err_d;
      i_rdata_q    <= i_rdata_d;
      d_valid_q    <= d_valid_d;
      d_err_q      <= d_err_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign i_valid = i_valid_q;
  assign i_err   = i_err_q;
  assign i_rdata = i_rdata_q;
  assign d_valid = d_valid_q;
  assign d_err   = d_err_q;
  assign d_rdata = d_rdata_q;
  assign busy    = (state_q == S_ACCESS);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vectors, corner sequences and a randomized
// run against a transaction-level model (busy window + scheduled response).
module tb_mem_port_arbiter;
  localparam int W     = 2;
  localparam int DEPTH = 8000;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_gnt, i_valid, i_err, d_gnt, d_valid, d_err;
  logic        mem_read, mem_write, busy;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

  logic        z_d_req;
  logic [31:0] z_d_addr;
  logic        z_i_gnt, z_i_valid, z_i_err, z_d_gnt, z_d_valid, z_d_err;
  logic        z_mem_read, z_mem_write, z_busy;
  logic [31:0] z_i_rdata, z_d_rdata, z_mem_addr, z_mem_wdata, z_mem_rdata;

  logic [31:0] tb_mem  [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WAIT_CYCLES(W), .DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_valid(i_valid), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt), .d_valid(d_valid),
    .d_rdata(d_rdata), .d_err(d_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.WAIT_CYCLES(0), .DEPTH_WORDS(DEPTH)) dut0 (
    .clk(clk), .rst(rst),
    .i_req(1'b0), .i_addr(32'h0), .i_gnt(z_i_gnt), .i_valid(z_i_valid), .i_rdata(z_i_rdata), .i_err(z_i_err),
    .d_req(z_d_req), .d_we(1'b0), .d_addr(z_d_addr), .d_wdata(32'h0), .d_gnt(z_d_gnt), .d_valid(z_d_valid),
    .d_rdata(z_d_rdata), .d_err(z_d_err),
    .mem_read(z_mem_read), .mem_write(z_mem_write), .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata),
    .mem_rdata(z_mem_rdata), .busy(z_busy)
  );

  always_comb begin
    mem_rdata = 32'h0;
    if (mem_read && (mem_addr[31:2] < 30'(DEPTH))) mem_rdata = tb_mem[mem_addr[14:2]];
  end

  always @(posedge clk) begin
    if (mem_write && (mem_addr[31:2] < 30'(DEPTH))) tb_mem[mem_addr[14:2]] <= mem_wdata;
  end

  assign z_mem_rdata = z_mem_read ? (z_mem_addr ^ 32'h5A5A_0000) : 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic idle_inputs();
    i_req = 0; d_req = 0; d_we = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
    z_d_req = 0; z_d_addr = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  typedef struct {
    bit          i_req;
    bit          d_req;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          exp_d;
    bit          exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  // Starts and ends at posedge+1.
  task automatic run_txn(input vec_t v, input string tag);
    int lat, nrd, nwr;
    bit got;
    i_req = v.i_req; d_req = v.d_req; d_we = v.we;
    i_addr = v.addr; d_addr = v.addr; d_wdata = v.wdata;
    @(negedge clk);
    chk({tag, "_d_gnt"}, 32'(d_gnt), 32'(v.exp_d));
    chk({tag, "_i_gnt"}, 32'(i_gnt), 32'(!v.exp_d));
    @(posedge clk); #1;
    idle_inputs();
    nrd = 0; nwr = 0; got = 0; lat = 0;
    for (int cyc = 1; cyc <= 20 && !got; cyc++) begin
      @(negedge clk);
      if (i_valid || d_valid) begin
        got = 1; lat = cyc;
      end else begin
        nrd += int'(mem_read); nwr += int'(mem_write);
        @(posedge clk); #1;
      end
    end
    chk({tag, "_latency"}, 32'(lat), 32'(W + 2));
    chk({tag, "_d_valid"}, 32'(d_valid), 32'(v.exp_d));
    chk({tag, "_i_valid"}, 32'(i_valid), 32'(!v.exp_d));
    chk({tag, "_rdata"}, v.exp_d ? d_rdata : i_rdata, v.exp_rdata);
    chk({tag, "_err"}, 32'(v.exp_d ? d_err : i_err), 32'(v.exp_err));
    chk({tag, "_reads"}, 32'(nrd), (!v.we && !v.exp_err) ? 32'(W + 1) : 32'h0);
    chk({tag, "_writes"}, 32'(nwr), (v.we && !v.exp_err) ? 32'h1 : 32'h0);
    if (got) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return {30'(DEPTH + int'($urandom_range(0, 3))), 2'b00};
    if (r == 1) return {30'(DEPTH - 1), 2'b00};
    return {30'($urandom_range(0, 31)), 2'b00};
  endfunction

  vec_t vecs [8];
  bit   exp_tie [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) tb_mem[i] <= 32'h1000_0000 + 32'(i);
    tb_mem[5]    <= 32'hDEAD_BEEF;
    tb_mem[16]   <= 32'h0BAD_F00D;
    tb_mem[7999] <= 32'hC0DE_7999;

    vecs[0] = '{1, 0, 0, 32'h14,        32'h0,          0, 0, 32'hDEAD_BEEF};
    vecs[1] = '{0, 1, 1, 32'h20,        32'h1234_5678,  1, 0, 32'h0};
    vecs[2] = '{0, 1, 0, 32'h20,        32'h0,          1, 0, 32'h1234_5678};
    vecs[3] = '{0, 1, 1, 32'd32000,     32'hAAAA_5555,  1, 1, 32'h0};
    vecs[4] = '{0, 1, 0, 32'd31996,     32'h0,          1, 0, 32'hC0DE_7999};
    vecs[5] = '{1, 0, 0, 32'd32000,     32'h0,          0, 1, 32'h0};
    vecs[6] = '{1, 0, 0, 32'h20,        32'h0,          0, 0, 32'h1234_5678};
    vecs[7] = '{0, 1, 0, 32'hFFFF_FFFC, 32'h0,          1, 1, 32'h0};

    if (RR_MODE) exp_tie = '{1, 0, 1, 0};
    else         exp_tie = '{1, 1, 1, 1};

    rst = 1'b1;
    do_reset();

    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_gnt", {30'h0, i_gnt, d_gnt}, 0);
    chk("rst_valid", {30'h0, i_valid, d_valid}, 0);
    chk("rst_err", {30'h0, i_err, d_err}, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_mem_ctl", {30'h0, mem_read, mem_write}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    @(posedge clk); #1;

    for (int k = 0; k < 8; k++) run_txn(vecs[k], $sformatf("vec%0d", k));
    chk("no_wrap_7999", tb_mem[7999], 32'hC0DE_7999);
    chk("store_20_mem", tb_mem[8], 32'h1234_5678);

    // Reset during the second ACCESS cycle of a store.
    d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hCAFE_BABE;
    @(negedge clk);
    chk("rstmid_gnt", 32'(d_gnt), 1);
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;
    chk("rstmid_busy_before", 32'(busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_busy", 32'(busy), 0);
    chk("rstmid_mem_write", 32'(mem_write), 0);
    chk("rstmid_i_rdata", i_rdata, 0);
    @(posedge clk); #3 rst = 1'b0;
    begin
      int nv;
      nv = 0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        nv += int'(d_valid) + int'(i_valid);
      end
      chk("rstmid_no_valid", 32'(nv), 0);
    end
    @(posedge clk); #1;
    run_txn('{0, 1, 0, 32'h40, 32'h0, 1, 0, 32'h0BAD_F00D}, "rstmid_reload");

    // Both ports held requesting across four grants.
    do_reset();
    i_req = 1; i_addr = 32'h14; d_req = 1; d_we = 0; d_addr = 32'h20;
    begin
      int n, ni;
      n = 0; ni = 0;
      for (int c = 0; c < 60 && n < 4; c++) begin
        @(negedge clk);
        if (i_gnt && d_gnt) chk("tie_both_gnt", 32'({i_gnt, d_gnt}), 32'h1);
        ni += int'(i_gnt);
        if (i_gnt || d_gnt) begin
          chk($sformatf("tie_grant%0d_is_d", n), 32'(d_gnt), 32'(exp_tie[n]));
          n++;
        end
        @(posedge clk); #1;
      end
      chk("tie_count", 32'(n), 4);
      chk("tie_i_gnts", 32'(ni), RR_MODE ? 32'd2 : 32'd0);
    end
    idle_inputs();
    repeat (W + 3) @(posedge clk);
    #1;

    // Zero-wait instance, three back-to-back loads.
    begin
      logic [31:0] za [3];
      int k;
      za = '{32'h100, 32'h204, 32'h3F8};
      k = 0;
      z_d_req = 1; z_d_addr = za[0];
      for (int c = 0; c < 7; c++) begin
        bit eg;
        @(negedge clk);
        eg = (c % 2 == 0) && (k < 3);
        chk($sformatf("w0_gnt_c%0d", c), 32'(z_d_gnt), 32'(eg));
        chk($sformatf("w0_busy_c%0d", c), 32'(z_busy), 32'(c % 2 == 1));
        chk($sformatf("w0_valid_c%0d", c), 32'(z_d_valid), 32'((c >= 2) && (c % 2 == 0)));
        if ((c >= 2) && (c % 2 == 0))
          chk($sformatf("w0_rdata_c%0d", c), z_d_rdata, za[c / 2 - 1] ^ 32'h5A5A_0000);
        if (eg) k++;
        @(posedge clk); #1;
        if (k == 3) z_d_req = 0;
        else z_d_addr = za[k];
      end
    end
    idle_inputs();

    // Randomized traffic against a transaction-level model.
    do_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = tb_mem[i];
    begin
      int m_left, m_resp_cyc, word;
      bit m_resp_pend, m_resp_d, m_resp_err, m_last_d;
      logic [31:0] m_resp_data, exp_ir, exp_dr;
      bit ion, don, g_i, g_d, ev_i, ev_d, ee_i, ee_d, win_d, any;
      logic [31:0] ra;
      m_left = 0; m_resp_pend = 0; m_resp_cyc = -1; m_last_d = 0;
      m_resp_d = 0; m_resp_err = 0; m_resp_data = 0;
      exp_ir = 0; exp_dr = 0; ion = 0; don = 0; g_i = 0; g_d = 0;
      for (int c = 0; c < 400; c++) begin
        if (g_i) ion = 0;
        if (g_d) don = 0;
        if (!ion && $urandom_range(0, 2) == 0) begin
          ion = 1; i_addr = rand_addr();
        end
        if (!don && $urandom_range(0, 2) == 0) begin
          don = 1; d_addr = rand_addr(); d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom;
        end
        i_req = ion; d_req = don;
        @(negedge clk);
        ev_i = 0; ev_d = 0; ee_i = 0; ee_d = 0;
        if (m_resp_pend && m_resp_cyc == c) begin
          m_resp_pend = 0;
          if (m_resp_d) begin ev_d = 1; ee_d = m_resp_err; exp_dr = m_resp_data; end
          else          begin ev_i = 1; ee_i = m_resp_err; exp_ir = m_resp_data; end
        end
        any = (m_left == 0) && (ion || don);
        if (ion && don) win_d = RR_MODE ? !m_last_d : 1'b1;
        else            win_d = don;
        g_d = any && win_d;
        g_i = any && !win_d;
        chk("rnd_busy", 32'(busy), 32'(m_left > 0));
        chk("rnd_i_gnt", 32'(i_gnt), 32'(g_i));
        chk("rnd_d_gnt", 32'(d_gnt), 32'(g_d));
        chk("rnd_i_valid", 32'(i_valid), 32'(ev_i));
        chk("rnd_d_valid", 32'(d_valid), 32'(ev_d));
        chk("rnd_i_err", 32'(i_err), 32'(ee_i));
        chk("rnd_d_err", 32'(d_err), 32'(ee_d));
        chk("rnd_i_rdata", i_rdata, exp_ir);
        chk("rnd_d_rdata", d_rdata, exp_dr);
        if (m_left > 0) m_left--;
        if (any) begin
          ra = win_d ? d_addr : i_addr;
          word = int'(ra[31:2]);
          m_resp_err = (word >= DEPTH);
          m_resp_d = win_d;
          if (m_resp_err || (win_d && d_we)) m_resp_data = 32'h0;
          else m_resp_data = ref_mem[word];
          if (win_d && d_we && !m_resp_err) ref_mem[word] = d_wdata;
          m_left = W + 1;
          m_resp_cyc = c + W + 2;
          m_resp_pend = 1;
          m_last_d = win_d;
        end
        @(posedge clk); #1;
      end
    end
    idle_inputs();
    repeat (W + 4) @(posedge clk);
    #1;
    for (int w = 0; w < 32; w++) chk($sformatf("rnd_mem_w%0d", w), tb_mem[w], ref_mem[w]);
    chk("rnd_mem_w7999", tb_mem[7999], ref_mem[7999]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
